// File: rtl/subleq_loader_mem.sv
// Unified program/data RAM for the subleq CPU with a streaming boot loader in front.
// LOAD fills RAM from address 0, then RUN releases the CPU and serves its bus plus one output port.
module subleq_loader_mem #(
  parameter int unsigned     BITS    = 8,
  parameter logic [BITS-1:0] IO_ADDR = {BITS{1'b1}}
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [BITS-1:0] load_data,
  input  logic            load_last,
  output logic            cpu_reset,
  input  logic            cpu_write,
  input  logic [BITS-1:0] cpu_address,
  inout  wire  [BITS-1:0] cpu_data,
  output logic            running,
  output logic [BITS:0]   load_count,
  output logic            out_valid,
  output logic [BITS-1:0] out_data
);

  typedef enum logic {StLoad, StRun} state_t;

  state_t          r_state;
  logic [BITS-1:0] r_ptr;
  logic [BITS:0]   r_count;
  logic            r_cpu_reset;
  logic            r_running;
  logic            r_out_valid;
  logic [BITS-1:0] r_out_data;
  logic [BITS-1:0] r_mem [2**BITS];

  logic            w_load_hs;
  logic            w_cpu_wr;
  logic            w_io_hit;
  logic            w_drive;
  logic [BITS-1:0] w_rd_data;

  assign w_load_hs = (r_state == StLoad) && load_valid;
  assign w_io_hit  = (cpu_address == IO_ADDR);
  assign w_cpu_wr  = (r_state == StRun) && cpu_write;

  // The CPU latches read data on the edge it presents the address, so reads are combinational.
  assign w_rd_data = w_io_hit ? '0 : r_mem[cpu_address];
  assign w_drive   = (r_state == StRun) && !cpu_write;
  assign cpu_data  = w_drive ? w_rd_data : {BITS{1'bz}};

  assign load_ready = (r_state == StLoad);
  assign cpu_reset  = r_cpu_reset;
  assign running    = r_running;
  assign load_count = r_count;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StLoad;
      r_ptr       <= '0;
      r_count     <= '0;
      r_cpu_reset <= 1'b1;
      r_running   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        StLoad: begin
          if (w_load_hs) begin
            r_ptr   <= r_ptr + 1'b1;
            r_count <= r_count + 1'b1;
            // Writing the top address ends the load; the pointer never wraps back into use.
            if (load_last || (r_ptr == {BITS{1'b1}})) begin
              r_state     <= StRun;
              r_cpu_reset <= 1'b0;
              r_running   <= 1'b1;
            end
          end
        end
        StRun: begin
          if (w_cpu_wr && w_io_hit) begin
            r_out_data  <= cpu_data;
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  // RAM has no reset so a program survives a reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_load_hs) begin
        r_mem[r_ptr] <= load_data;
      end else if (w_cpu_wr && !w_io_hit) begin
        r_mem[cpu_address] <= cpu_data;
      end
    end
  end

endmodule

// File: tb/tb_subleq_loader_mem.sv
// Scoreboarded bench for subleq_loader_mem: an 8-bit instance under directed and random traffic,
// and a 3-bit instance for load auto-termination at the top address.
module tb_subleq_loader_mem;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       load_valid, load_last;
  logic [7:0] load_data;
  wire        load_ready, cpu_reset, running, out_valid;
  wire  [8:0] load_count;
  wire  [7:0] out_data;
  logic       cpu_write;
  logic [7:0] cpu_address, drv_data;
  wire  [7:0] cpu_data;
  assign cpu_data = cpu_write ? drv_data : 8'bz;

  logic       s_valid, s_last;
  logic [2:0] s_data;
  wire        s_ready, s_cpu_reset, s_running, s_out_valid;
  wire  [3:0] s_count;
  wire  [2:0] s_out_data;
  logic       s_write;
  logic [2:0] s_addr, s_drv;
  wire  [2:0] s_cpu_data;
  assign s_cpu_data = s_write ? s_drv : 3'bz;

  subleq_loader_mem #(.BITS(8), .IO_ADDR(8'hFF)) u_dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .cpu_reset(cpu_reset), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .running(running),
    .load_count(load_count), .out_valid(out_valid), .out_data(out_data)
  );

  subleq_loader_mem #(.BITS(3), .IO_ADDR(3'd7)) u_dut3 (
    .clock(clock), .reset(reset), .load_valid(s_valid), .load_ready(s_ready),
    .load_data(s_data), .load_last(s_last), .cpu_reset(s_cpu_reset), .cpu_write(s_write),
    .cpu_address(s_addr), .cpu_data(s_cpu_data), .running(s_running),
    .load_count(s_count), .out_valid(s_out_valid), .out_data(s_out_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_out_q [$];
  logic [7:0] exp_rd_q  [$];
  logic       rd_req = 1'b0;

  // Reference model: what the program memory should hold, and which words are defined.
  logic [7:0] mem_m   [256];
  bit         known_m [256];
  int         ptr_m;
  logic [2:0] mem3_m  [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues on the falling edge.
  always @(negedge clock) begin
    if (out_valid) begin
      if (exp_out_q.size() == 0) begin
        chk("out_valid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("out_data", {24'd0, out_data}, {24'd0, exp_out_q.pop_front()});
      end
    end
    if (rd_req) begin
      if (exp_rd_q.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
      else chk("cpu_read", {24'd0, cpu_data}, {24'd0, exp_rd_q.pop_front()});
    end
    if (cpu_write && running) chk("bus_write_value", {24'd0, cpu_data}, {24'd0, drv_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] d, input bit last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    mem_m[ptr_m]   = d;
    known_m[ptr_m] = 1'b1;
    ptr_m++;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    cpu_write   = 1'b1;
    cpu_address = a;
    drv_data    = d;
    if (a == 8'hFF) begin
      exp_out_q.push_back(d);
    end else begin
      mem_m[a]   = d;
      known_m[a] = 1'b1;
    end
    step();
    cpu_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    cpu_write   = 1'b0;
    cpu_address = a;
    exp_rd_q.push_back((a == 8'hFF) ? 8'h00 : mem_m[a]);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    logic [7:0] a;
    int unsigned r;
    reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    cpu_write = 1'b0; cpu_address = '0; drv_data = '0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_write = 1'b0; s_addr = '0; s_drv = '0;
    ptr_m = 0;
    step(); step();
    reset = 1'b0;

    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_load_count", {23'd0, load_count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);

    // 3-bit instance: eight words with no last marker end the load by themselves.
    for (int i = 0; i < 8; i++) begin
      chk("s_ready_during_load", {31'd0, s_ready}, 32'd1);
      s_valid   = 1'b1;
      s_data    = 3'($urandom);
      mem3_m[i] = s_data;
      step();
    end
    chk("s_running_after_8", {31'd0, s_running}, 32'd1);
    chk("s_cpu_reset_after_8", {31'd0, s_cpu_reset}, 32'd0);
    chk("s_count_8", {28'd0, s_count}, 32'd8);
    chk("s_ready_after_8", {31'd0, s_ready}, 32'd0);
    step();
    s_valid = 1'b0;
    chk("s_count_9th_refused", {28'd0, s_count}, 32'd8);
    for (int i = 0; i < 7; i++) begin
      s_addr = 3'(i);
      #1;
      chk("s_read", {29'd0, s_cpu_data}, {29'd0, mem3_m[i]});
    end
    s_addr = 3'd7;
    #1;
    chk("s_read_io", {29'd0, s_cpu_data}, 32'd0);

    // Load 5,6,7 with a 3-cycle gap after the first word.
    load(8'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      load_data = 8'($urandom);
      step();
      chk("gap_count", {23'd0, load_count}, 32'd1);
      chk("gap_ready", {31'd0, load_ready}, 32'd1);
      chk("gap_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    end
    load(8'd6, 1'b0);
    chk("pre_last_running", {31'd0, running}, 32'd0);
    load(8'd7, 1'b1);
    chk("last_running", {31'd0, running}, 32'd1);
    chk("last_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("last_load_ready", {31'd0, load_ready}, 32'd0);
    chk("last_count", {23'd0, load_count}, 32'd3);
    cpu_rd(8'd1);
    cpu_rd(8'd0);
    cpu_rd(8'd2);

    cpu_wr(8'd3, 8'h2A);
    cpu_rd(8'd3);

    cpu_wr(8'hFF, 8'h11);
    cpu_wr(8'hFF, 8'h22);
    cpu_rd(8'hFF);
    chk("io_out_data", {24'd0, out_data}, 32'h22);
    chk("io_no_pulse", {31'd0, out_valid}, 32'd0);

    // Random CPU traffic with load-port noise that must be ignored in RUN.
    for (int i = 0; i < 400; i++) begin
      load_valid = 1'($urandom);
      load_last  = 1'($urandom);
      load_data  = 8'($urandom);
      r = $urandom_range(0, 3);
      a = 8'($urandom);
      if (r == 0)                       cpu_wr(8'hFF, 8'($urandom));
      else if (r == 1)                  cpu_wr(a, 8'($urandom));
      else if (a == 8'hFF || known_m[a]) cpu_rd(a);
      else                              cpu_rd(8'd0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("run_count_stable", {23'd0, load_count}, 32'd3);
    chk("run_still_running", {31'd0, running}, 32'd1);

    // Reset in RUN puts the CPU straight back into reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    ptr_m = 0;
    chk("midrun_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrun_running", {31'd0, running}, 32'd0);
    chk("midrun_out_data", {24'd0, out_data}, 32'd0);
    chk("midrun_ready", {31'd0, load_ready}, 32'd1);

    // Abandon a partial load, then reload one word.
    load(8'hA1, 1'b0);
    load(8'hB2, 1'b0);
    chk("partial_count", {23'd0, load_count}, 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ptr_m = 0;
    chk("reload_count0", {23'd0, load_count}, 32'd0);
    load(8'd9, 1'b1);
    chk("reload_count1", {23'd0, load_count}, 32'd1);
    chk("reload_running", {31'd0, running}, 32'd1);
    chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    cpu_rd(8'd0);
    cpu_rd(8'd1);

    step(); step();
    chk("out_queue_drained", exp_out_q.size(), 32'd0);
    chk("rd_queue_drained", exp_rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
